reg_writeback_queue: RTL and testbench

- Write-side front end for the per-thread register file.
- Collects destination-register results from the ALU, LSU and CONST paths over valid/ready handshakes and arbitrates one per cycle.
- Buffers accepted results in a small FIFO and drains them in order onto the register file's single write port.
- Filters writes aimed at the read-only registers R13–R15 (%blockIdx, %blockDim, %threadIdx), so the register file only ever sees legal writes.

---
 rtl/reg_writeback_queue.sv | 123 ++++++++++++
 tb/tb_reg_writeback_queue.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/reg_writeback_queue.sv
// Register-file write front end: arbitrates LSU/ALU/CONST results into an in-order FIFO and drops
// writes to read-only registers. Optional same-cycle bypass when empty is enabled by WB_BYPASS_EN.
module reg_writeback_queue #(
   parameter int DATA_BITS = 8,
   parameter int DEPTH     = 4,
   parameter int RO_BASE   = 13
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         enable,
   input  logic                         flush,
   input  logic                         lsu_valid,
   output logic                         lsu_ready,
   input  logic [3:0]                   lsu_rd,
   input  logic [DATA_BITS-1:0]         lsu_data,
   input  logic                         alu_valid,
   output logic                         alu_ready,
   input  logic [3:0]                   alu_rd,
   input  logic [DATA_BITS-1:0]         alu_data,
   input  logic                         const_valid,
   output logic                         const_ready,
   input  logic [3:0]                   const_rd,
   input  logic [DATA_BITS-1:0]         const_data,
   output logic                         reg_write_enable,
   output logic [3:0]                   reg_rd_address,
   output logic [DATA_BITS-1:0]         reg_write_data,
   input  logic                         reg_write_ready,
   output logic                         empty,
   output logic                         full,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         illegal_write
);

   localparam int CW = $clog2(DEPTH+1);
   localparam int PW = $clog2(DEPTH);

   logic [3:0]           mem_rd   [DEPTH];
   logic [DATA_BITS-1:0] mem_data [DEPTH];
   logic [PW-1:0]        wptr, rptr;

   logic                 push, push_legal, push_en, pop, bypass;
   logic [3:0]           sel_rd;
   logic [DATA_BITS-1:0] sel_data;

   assign empty = (count == CW'(0));
   assign full  = (count == CW'(DEPTH));

   // Readies are independent of the same-cycle pop: no path from reg_write_ready.
   assign lsu_ready   = enable & ~flush & ~full;
   assign alu_ready   = lsu_ready & ~lsu_valid;
   assign const_ready = alu_ready & ~alu_valid;

   always_comb begin
      push     = 1'b0;
      sel_rd   = '0;
      sel_data = '0;
      if (lsu_valid && lsu_ready) begin
         push     = 1'b1;
         sel_rd   = lsu_rd;
         sel_data = lsu_data;
      end else if (alu_valid && alu_ready) begin
         push     = 1'b1;
         sel_rd   = alu_rd;
         sel_data = alu_data;
      end else if (const_valid && const_ready) begin
         push     = 1'b1;
         sel_rd   = const_rd;
         sel_data = const_data;
      end
   end

   assign push_legal = push & (int'(sel_rd) < RO_BASE);

`ifdef WB_BYPASS_EN
   assign bypass = empty & enable & ~flush & reg_write_ready & push_legal;
`else
   assign bypass = 1'b0;
`endif

   assign push_en = push_legal & ~bypass;
   assign pop     = enable & ~empty & reg_write_ready & ~flush;

   always_comb begin
      reg_write_enable = (enable & ~empty) | bypass;
      reg_rd_address   = '0;
      reg_write_data   = '0;
      if (bypass) begin
         reg_rd_address = sel_rd;
         reg_write_data = sel_data;
      end else if (!empty) begin
         reg_rd_address = mem_rd[rptr];
         reg_write_data = mem_data[rptr];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wptr          <= '0;
         rptr          <= '0;
         count         <= '0;
         illegal_write <= 1'b0;
      end else if (flush) begin
         wptr          <= '0;
         rptr          <= '0;
         count         <= '0;
         illegal_write <= 1'b0;
      end else begin
         if (push_en) wptr <= wptr + PW'(1);
         if (pop)     rptr <= rptr + PW'(1);
         if (push_en && !pop)      count <= count + CW'(1);
         else if (!push_en && pop) count <= count - CW'(1);
         illegal_write <= push & ~push_legal;
      end
   end

   always_ff @(posedge clk) begin
      if (push_en) begin
         mem_rd[wptr]   <= sel_rd;
         mem_data[wptr] <= sel_data;
      end
   end

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Directed bench for reg_writeback_queue: per-cycle vector table plus hand sequences for async reset.
module tb_reg_writeback_queue;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable, flush;
   logic       lsu_valid, alu_valid, const_valid;
   logic       lsu_ready, alu_ready, const_ready;
   logic [3:0] lsu_rd, alu_rd, const_rd;
   logic [7:0] lsu_data, alu_data, const_data;
   logic       reg_write_enable, reg_write_ready;
   logic [3:0] reg_rd_address;
   logic [7:0] reg_write_data;
   logic       empty, full, illegal_write;
   logic [2:0] count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   reg_writeback_queue dut (
      .clk(clk), .reset(reset), .enable(enable), .flush(flush),
      .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
      .const_valid(const_valid), .const_ready(const_ready), .const_rd(const_rd), .const_data(const_data),
      .reg_write_enable(reg_write_enable), .reg_rd_address(reg_rd_address),
      .reg_write_data(reg_write_data), .reg_write_ready(reg_write_ready),
      .empty(empty), .full(full), .count(count), .illegal_write(illegal_write)
   );

   typedef struct packed {
      logic       en, fl;
      logic       lv; logic [3:0] lrd; logic [7:0] ld;
      logic       av; logic [3:0] ard; logic [7:0] ad;
      logic       cv; logic [3:0] crd; logic [7:0] cd;
      logic       rwr;
      logic       lr, ar, cr, we;
      logic [3:0] wa; logic [7:0] wd;
      logic [2:0] cnt;
      logic       emp, ful, ill;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic en, fl,
                      input logic lv, input logic [3:0] lrd, input logic [7:0] ld,
                      input logic av, input logic [3:0] ard, input logic [7:0] ad,
                      input logic cv, input logic [3:0] crd, input logic [7:0] cd,
                      input logic rwr,
                      input logic lr, ar, cr, we,
                      input logic [3:0] wa, input logic [7:0] wd, input logic [2:0] cnt,
                      input logic emp, ful, ill);
      vecs.push_back('{en, fl, lv, lrd, ld, av, ard, ad, cv, crd, cd, rwr,
                       lr, ar, cr, we, wa, wd, cnt, emp, ful, ill});
   endtask

   task automatic idle_inputs();
      enable = 1'b1; flush = 1'b0;
      lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
      alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
      const_valid = 1'b0; const_rd = '0; const_data = '0;
      reg_write_ready = 1'b0;
   endtask

   initial begin
      idle_inputs();
      reset = 1'b0;
      #1;
      chk("rst_count", 32'(count), 0);
      chk("rst_empty", 32'(empty), 1);
      chk("rst_full",  32'(full), 0);
      chk("rst_we",    32'(reg_write_enable), 0);
      chk("rst_ill",   32'(illegal_write), 0);

      //   en fl lv lrd ld     av ard ad     cv crd cd     rwr  lr ar cr we wa wd    cnt emp ful ill
      // priority: LSU > ALU > CONST, drained in acceptance order
      add(1,0, 1,1,8'h11,   1,2,8'h22,   1,3,8'h33,   0,   1,0,0,0, 0,8'h00, 0,1,0,0); // 0
      add(1,0, 0,0,8'h00,   1,2,8'h22,   1,3,8'h33,   1,   1,1,0,1, 1,8'h11, 1,0,0,0); // 1
      add(1,0, 0,0,8'h00,   0,0,8'h00,   1,3,8'h33,   1,   1,1,1,1, 2,8'h22, 1,0,0,0); // 2
      add(1,0, 0,0,8'h00,   0,0,8'h00,   0,0,8'h00,   1,   1,1,1,1, 3,8'h33, 1,0,0,0); // 3
      add(1,0, 0,0,8'h00,   0,0,8'h00,   0,0,8'h00,   0,   1,1,1,0, 0,8'h00, 0,1,0,0); // 4
      // fill to full with the register file stalled
      add(1,0, 0,0,8'h00,   1,4,8'hA0,   0,0,8'h00,   0,   1,1,0,0, 0,8'h00, 0,1,0,0); // 5
      add(1,0, 0,0,8'h00,   1,5,8'hA1,   0,0,8'h00,   0,   1,1,0,1, 4,8'hA0, 1,0,0,0); // 6
      add(1,0, 0,0,8'h00,   1,6,8'hA2,   0,0,8'h00,   0,   1,1,0,1, 4,8'hA0, 2,0,0,0); // 7
      add(1,0, 0,0,8'h00,   1,7,8'hA3,   0,0,8'h00,   0,   1,1,0,1, 4,8'hA0, 3,0,0,0); // 8
      add(1,0, 0,0,8'h00,   1,8,8'hA4,   0,0,8'h00,   0,   0,0,0,1, 4,8'hA0, 4,0,1,0); // 9
      add(1,0, 0,0,8'h00,   1,8,8'hA4,   0,0,8'h00,   1,   0,0,0,1, 4,8'hA0, 4,0,1,0); // 10
      // pointers wrap while pushing and popping together
      add(1,0, 0,0,8'h00,   1,8,8'hA4,   0,0,8'h00,   1,   1,1,0,1, 5,8'hA1, 3,0,0,0); // 11
      add(1,0, 0,0,8'h00,   1,9,8'hA5,   0,0,8'h00,   1,   1,1,0,1, 6,8'hA2, 3,0,0,0); // 12
      add(1,0, 0,0,8'h00,   1,10,8'hA6,  0,0,8'h00,   1,   1,1,0,1, 7,8'hA3, 3,0,0,0); // 13
      add(1,0, 0,0,8'h00,   1,11,8'hA7,  0,0,8'h00,   1,   1,1,0,1, 8,8'hA4, 3,0,0,0); // 14
      add(1,0, 0,0,8'h00,   0,0,8'h00,   0,0,8'h00,   1,   1,1,1,1, 9,8'hA5, 3,0,0,0); // 15
      add(1,0, 0,0,8'h00,   0,0,8'h00,   0,0,8'h00,   1,   1,1,1,1, 10,8'hA6,2,0,0,0); // 16
      add(1,0, 0,0,8'h00,   0,0,8'h00,   0,0,8'h00,   1,   1,1,1,1, 11,8'hA7,1,0,0,0); // 17
      // read-only targets are consumed and reported, never queued
      add(1,0, 0,0,8'h00,   0,0,8'h00,   1,13,8'h07,  1,   1,1,1,0, 0,8'h00, 0,1,0,0); // 18
      add(1,0, 0,0,8'h00,   0,0,8'h00,   0,0,8'h00,   1,   1,1,1,0, 0,8'h00, 0,1,0,1); // 19
      add(1,0, 0,0,8'h00,   0,0,8'h00,   0,0,8'h00,   1,   1,1,1,0, 0,8'h00, 0,1,0,0); // 20
      add(1,0, 1,15,8'h99,  0,0,8'h00,   0,0,8'h00,   1,   1,0,0,0, 0,8'h00, 0,1,0,0); // 21
      add(1,0, 0,0,8'h00,   0,0,8'h00,   0,0,8'h00,   1,   1,1,1,0, 0,8'h00, 0,1,0,1); // 22
      add(1,0, 0,0,8'h00,   0,0,8'h00,   0,0,8'h00,   1,   1,1,1,0, 0,8'h00, 0,1,0,0); // 23
      // flush with two entries queued and an ALU result waiting
      add(1,0, 0,0,8'h00,   1,1,8'h10,   0,0,8'h00,   0,   1,1,0,0, 0,8'h00, 0,1,0,0); // 24
      add(1,0, 0,0,8'h00,   1,2,8'h20,   0,0,8'h00,   0,   1,1,0,1, 1,8'h10, 1,0,0,0); // 25
      add(1,1, 0,0,8'h00,   1,3,8'h30,   0,0,8'h00,   0,   0,0,0,1, 1,8'h10, 2,0,0,0); // 26
      add(1,0, 0,0,8'h00,   1,3,8'h30,   0,0,8'h00,   0,   1,1,0,0, 0,8'h00, 0,1,0,0); // 27
      add(1,0, 0,0,8'h00,   0,0,8'h00,   0,0,8'h00,   1,   1,1,1,1, 3,8'h30, 1,0,0,0); // 28
      add(1,0, 0,0,8'h00,   0,0,8'h00,   0,0,8'h00,   1,   1,1,1,0, 0,8'h00, 0,1,0,0); // 29
      // enable low freezes the queue
      add(1,0, 1,6,8'h66,   0,0,8'h00,   0,0,8'h00,   0,   1,0,0,0, 0,8'h00, 0,1,0,0); // 30
      add(0,0, 1,7,8'h77,   0,0,8'h00,   0,0,8'h00,   1,   0,0,0,0, 6,8'h66, 1,0,0,0); // 31
      add(1,0, 0,0,8'h00,   0,0,8'h00,   0,0,8'h00,   1,   1,1,1,1, 6,8'h66, 1,0,0,0); // 32
      add(1,0, 0,0,8'h00,   0,0,8'h00,   0,0,8'h00,   1,   1,1,1,0, 0,8'h00, 0,1,0,0); // 33
      // push into an empty queue with the register file ready
`ifdef WB_BYPASS_EN
      add(1,0, 1,4,8'hC3,   0,0,8'h00,   0,0,8'h00,   1,   1,0,0,1, 4,8'hC3, 0,1,0,0); // 34
      add(1,0, 0,0,8'h00,   0,0,8'h00,   0,0,8'h00,   1,   1,1,1,0, 0,8'h00, 0,1,0,0); // 35
`else
      add(1,0, 1,4,8'hC3,   0,0,8'h00,   0,0,8'h00,   1,   1,0,0,0, 0,8'h00, 0,1,0,0); // 34
      add(1,0, 0,0,8'h00,   0,0,8'h00,   0,0,8'h00,   1,   1,1,1,1, 4,8'hC3, 1,0,0,0); // 35
`endif
      add(1,0, 0,0,8'h00,   0,0,8'h00,   0,0,8'h00,   1,   1,1,1,0, 0,8'h00, 0,1,0,0); // 36

      @(negedge clk);
      reset = 1'b1;

      foreach (vecs[i]) begin
         @(negedge clk);
         enable = vecs[i].en;  flush = vecs[i].fl;
         lsu_valid = vecs[i].lv;   lsu_rd = vecs[i].lrd;   lsu_data = vecs[i].ld;
         alu_valid = vecs[i].av;   alu_rd = vecs[i].ard;   alu_data = vecs[i].ad;
         const_valid = vecs[i].cv; const_rd = vecs[i].crd; const_data = vecs[i].cd;
         reg_write_ready = vecs[i].rwr;
         #1;
         chk($sformatf("v%0d_lsu_ready", i),   32'(lsu_ready),        32'(vecs[i].lr));
         chk($sformatf("v%0d_alu_ready", i),   32'(alu_ready),        32'(vecs[i].ar));
         chk($sformatf("v%0d_const_ready", i), 32'(const_ready),      32'(vecs[i].cr));
         chk($sformatf("v%0d_we", i),          32'(reg_write_enable), 32'(vecs[i].we));
         chk($sformatf("v%0d_addr", i),        32'(reg_rd_address),   32'(vecs[i].wa));
         chk($sformatf("v%0d_data", i),        32'(reg_write_data),   32'(vecs[i].wd));
         chk($sformatf("v%0d_count", i),       32'(count),            32'(vecs[i].cnt));
         chk($sformatf("v%0d_empty", i),       32'(empty),            32'(vecs[i].emp));
         chk($sformatf("v%0d_full", i),        32'(full),             32'(vecs[i].ful));
         chk($sformatf("v%0d_illegal", i),     32'(illegal_write),    32'(vecs[i].ill));
      end

      // queue three entries, then assert reset between edges
      @(negedge clk);
      idle_inputs();
      lsu_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         lsu_rd = 4'(k + 1);
         lsu_data = 8'(8'h40 + k);
         @(negedge clk);
      end
      lsu_valid = 1'b0;
      #1;
      chk("pre_rst_count", 32'(count), 3);
      #2;
      reset = 1'b0;
      #1;
      chk("mid_rst_count", 32'(count), 0);
      chk("mid_rst_empty", 32'(empty), 1);
      chk("mid_rst_we",    32'(reg_write_enable), 0);
      chk("mid_rst_addr",  32'(reg_rd_address), 0);
      chk("mid_rst_data",  32'(reg_write_data), 0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      lsu_valid = 1'b1; lsu_rd = 4'd2; lsu_data = 8'h5A;
      @(negedge clk);
      lsu_valid = 1'b0;
      #1;
      chk("post_rst_we",    32'(reg_write_enable), 1);
      chk("post_rst_addr",  32'(reg_rd_address), 2);
      chk("post_rst_data",  32'(reg_write_data), 32'h5A);
      chk("post_rst_count", 32'(count), 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
